// File: rtl/multdiv_issue_ctrl_pkg.sv
// Shared types and defaults for the multdiv issue controller.
package multdiv_issue_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 64;
  localparam int unsigned DEF_RSTATUS_REG    = 30;
  localparam int unsigned DEF_MULT_EXC_CODE  = 4;
  localparam int unsigned DEF_DIV_EXC_CODE   = 5;
  localparam int unsigned DEF_TIMEOUT_CODE   = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  // Registered writeback payload.
  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_t;

  // Status code reported when multdiv flags an exception for the given op.
  function automatic logic [DATA_W-1:0] exc_code(input op_e op,
                                                 input int unsigned mult_code,
                                                 input int unsigned div_code);
    return (op == OP_MULT) ? DATA_W'(mult_code) : DATA_W'(div_code);
  endfunction

endpackage

// File: rtl/multdiv_issue_ctrl_if.sv
// Execute-stage, multdiv and writeback signals of the issue controller.
interface multdiv_issue_ctrl_if;
  import multdiv_issue_ctrl_pkg::*;

  logic              ex_valid;
  logic              ex_is_mult;
  logic              ex_is_div;
  logic              ex_flush;
  logic [DATA_W-1:0] ex_operandA;
  logic [DATA_W-1:0] ex_operandB;
  logic [REG_W-1:0]  ex_rd;
  logic              ctrl_MULT;
  logic              ctrl_DIV;
  logic [DATA_W-1:0] data_operandA;
  logic [DATA_W-1:0] data_operandB;
  logic [DATA_W-1:0] data_result;
  logic              data_exception;
  logic              data_resultRDY;
  logic              stall;
  logic              wb_valid;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              err_timeout;

  // Controller side.
  modport slave (
    input  ex_valid, ex_is_mult, ex_is_div, ex_flush, ex_operandA, ex_operandB, ex_rd,
    input  data_result, data_exception, data_resultRDY,
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output stall, wb_valid, wb_rd, wb_data, err_timeout
  );

  // Pipeline / multdiv environment side.
  modport master (
    output ex_valid, ex_is_mult, ex_is_div, ex_flush, ex_operandA, ex_operandB, ex_rd,
    output data_result, data_exception, data_resultRDY,
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  stall, wb_valid, wb_rd, wb_data, err_timeout
  );
endinterface

// File: rtl/multdiv_issue_ctrl_timeout.sv
// WAIT-state cycle counter with a registered terminal-count flag.
module multdiv_timeout_counter #(
  parameter int unsigned TERMINAL = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int unsigned CNT_W = $clog2(TERMINAL + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc_q;

  // Next count: clear wins, saturate at terminal.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count and terminal flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= (cnt_d == CNT_W'(TERMINAL));
    end
  end

  assign tc_o = tc_q;
endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issues mult/div ops to multdiv, stalls until done, writes back result or status.
module multdiv_issue_ctrl
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned RSTATUS_REG    = DEF_RSTATUS_REG,
  parameter int unsigned MULT_EXC_CODE  = DEF_MULT_EXC_CODE,
  parameter int unsigned DIV_EXC_CODE   = DEF_DIV_EXC_CODE,
  parameter int unsigned TIMEOUT_CODE   = DEF_TIMEOUT_CODE
) (
  input logic                 clock,
  input logic                 ctrl_reset_n,
  multdiv_issue_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              ctrl_mult_q, ctrl_mult_d, ctrl_div_q, ctrl_div_d;
  logic              err_timeout_q, err_timeout_d;
  wb_t               wb_q, wb_d;
  logic              start_c, stall_c, cnt_clr_c, cnt_en_c, timeout_tc;

  assign start_c = bus.ex_valid & (bus.ex_is_mult | bus.ex_is_div);

  multdiv_timeout_counter #(
    .TERMINAL(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i (clock),
    .rst_ni(ctrl_reset_n),
    .clr_i (cnt_clr_c),
    .en_i  (cnt_en_c),
    .tc_o  (timeout_tc)
  );

  // Next-state, latch and writeback decode.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    opa_d         = opa_q;
    opb_d         = opb_q;
    rd_d          = rd_q;
    ctrl_mult_d   = 1'b0;
    ctrl_div_d    = 1'b0;
    err_timeout_d = 1'b0;
    wb_d          = '0;
    stall_c       = 1'b0;
    cnt_clr_c     = 1'b0;
    cnt_en_c      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        stall_c = start_c;
        if (start_c) begin
          op_d        = bus.ex_is_mult ? OP_MULT : OP_DIV;
          opa_d       = bus.ex_operandA;
          opb_d       = bus.ex_operandB;
          rd_d        = bus.ex_rd;
          ctrl_mult_d = bus.ex_is_mult;
          ctrl_div_d  = !bus.ex_is_mult;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // RDY is ignored here: multdiv's ready may still be stale.
        stall_c   = 1'b1;
        cnt_clr_c = 1'b1;
        state_d   = bus.ex_flush ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        stall_c  = 1'b1;
        cnt_en_c = 1'b1;
        if (bus.ex_flush) begin
          state_d = ST_IDLE;
        end else if (bus.data_resultRDY) begin
          state_d = ST_WB;
          if (bus.data_exception) begin
            wb_d.valid = 1'b1;
            wb_d.rd    = REG_W'(RSTATUS_REG);
            wb_d.data  = exc_code(op_q, MULT_EXC_CODE, DIV_EXC_CODE);
          end else begin
            // A normal result targeting r0 is dropped.
            wb_d.valid = (rd_q != '0);
            wb_d.rd    = (rd_q != '0) ? rd_q : '0;
            wb_d.data  = (rd_q != '0) ? bus.data_result : '0;
          end
        end else if (timeout_tc) begin
          state_d       = ST_WB;
          err_timeout_d = 1'b1;
          wb_d.valid    = 1'b1;
          wb_d.rd       = REG_W'(RSTATUS_REG);
          wb_d.data     = DATA_W'(TIMEOUT_CODE);
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand latches and registered outputs.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_MULT;
      opa_q         <= '0;
      opb_q         <= '0;
      rd_q          <= '0;
      ctrl_mult_q   <= 1'b0;
      ctrl_div_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      wb_q          <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      opa_q         <= opa_d;
      opb_q         <= opb_d;
      rd_q          <= rd_d;
      ctrl_mult_q   <= ctrl_mult_d;
      ctrl_div_q    <= ctrl_div_d;
      err_timeout_q <= err_timeout_d;
      wb_q          <= wb_d;
    end
  end

  assign bus.ctrl_MULT     = ctrl_mult_q;
  assign bus.ctrl_DIV      = ctrl_div_q;
  assign bus.data_operandA = opa_q;
  assign bus.data_operandB = opb_q;
  assign bus.stall         = stall_c;
  assign bus.wb_valid      = wb_q.valid;
  assign bus.wb_rd         = wb_q.rd;
  assign bus.wb_data       = wb_q.data;
  assign bus.err_timeout   = err_timeout_q;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed self-checking bench for multdiv_issue_ctrl.
module tb_multdiv_issue_ctrl;
  import multdiv_issue_ctrl_pkg::*;

  logic clock = 1'b0;
  logic ctrl_reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  multdiv_issue_ctrl_if bus();

  multdiv_issue_ctrl dut (
    .clock       (clock),
    .ctrl_reset_n(ctrl_reset_n),
    .bus         (bus)
  );

  always #5 clock = ~clock;

  // Single comparison point.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_quiet();
    bus.ex_valid       = 1'b0;
    bus.ex_is_mult     = 1'b0;
    bus.ex_is_div      = 1'b0;
    bus.ex_flush       = 1'b0;
    bus.ex_operandA    = '0;
    bus.ex_operandB    = '0;
    bus.ex_rd          = '0;
    bus.data_result    = '0;
    bus.data_exception = 1'b0;
    bus.data_resultRDY = 1'b0;
  endtask

  // One operation: start at cycle 0, RDY at rdy_at, flush at flush_at (0 = none),
  // run until end_at (0 = until err_timeout or 100 cycles).
  task automatic run_op(input string name, input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input int rdy_at, input logic [31:0] res, input logic exc,
                        input int flush_at, input int end_at, input logic stale,
                        input logic exp_wb, input logic [4:0] exp_rd,
                        input logic [31:0] exp_data, input logic exp_to);
    int mult_p = 0, div_p = 0, pulse_cyc = -1, wb_cnt = 0, wb_cyc = -1, to_cnt = 0;
    int stall_bad = 0, quiet_bad = 0, opnd_bad = 0, c = 0;
    logic [4:0]  got_rd = '0;
    logic [31:0] got_data = '0;
    logic exp_stall;
    logic done = 1'b0;

    @(posedge clock); #1;
    bus.ex_valid       = 1'b1;
    bus.ex_is_mult     = m;
    bus.ex_is_div      = d;
    bus.ex_operandA    = a;
    bus.ex_operandB    = b;
    bus.ex_rd          = rd;
    bus.ex_flush       = 1'b0;
    bus.data_resultRDY = stale;
    bus.data_result    = 32'hDEAD;
    bus.data_exception = stale;
    #1;
    chk({name, ".stall_c0"}, 32'(bus.stall), 32'd1);

    while (!done) begin
      @(posedge clock); #1;
      c++;
      bus.ex_valid       = 1'b0;
      bus.ex_is_mult     = 1'b0;
      bus.ex_is_div      = 1'b0;
      bus.ex_operandA    = '1;
      bus.ex_operandB    = '1;
      bus.ex_rd          = '1;
      bus.ex_flush       = (c == flush_at);
      bus.data_resultRDY = (c == rdy_at) || (stale && c == 1);
      bus.data_result    = (c == rdy_at) ? res : 32'hDEAD;
      bus.data_exception = (c == rdy_at) ? exc : 1'b1;
      #1;
      if (flush_at > 0)    exp_stall = (c <= flush_at);
      else if (end_at > 0) exp_stall = (c < end_at);
      else                 exp_stall = !bus.err_timeout;
      if (bus.stall !== exp_stall) stall_bad++;
      if (bus.ctrl_MULT) begin mult_p++; pulse_cyc = c; end
      if (bus.ctrl_DIV)  begin div_p++;  pulse_cyc = c; end
      if (bus.wb_valid) begin
        wb_cnt++; wb_cyc = c; got_rd = bus.wb_rd; got_data = bus.wb_data;
      end else if ((bus.wb_rd != '0 || bus.wb_data != '0) && !(c == end_at && flush_at == 0)) begin
        quiet_bad++;
      end
      if (bus.err_timeout) to_cnt++;
      if ((flush_at == 0 || c <= flush_at) &&
          (bus.data_operandA !== a || bus.data_operandB !== b)) opnd_bad++;
      done = (end_at > 0) ? (c >= end_at) : (bus.err_timeout || c >= 100);
    end

    chk({name, ".mult_pulses"}, 32'(mult_p), 32'(m));
    chk({name, ".div_pulses"},  32'(div_p),  32'(!m && d));
    chk({name, ".pulse_cycle"}, 32'(pulse_cyc), 32'd1);
    chk({name, ".stall_profile"}, 32'(stall_bad), 32'd0);
    chk({name, ".operands_stable"}, 32'(opnd_bad), 32'd0);
    chk({name, ".wb_quiet"}, 32'(quiet_bad), 32'd0);
    chk({name, ".wb_count"}, 32'(wb_cnt), 32'(exp_wb));
    chk({name, ".timeouts"}, 32'(to_cnt), 32'(exp_to));
    if (exp_wb) begin
      chk({name, ".wb_rd"},   32'(got_rd), 32'(exp_rd));
      chk({name, ".wb_data"}, got_data, exp_data);
      if (end_at > 0) chk({name, ".wb_cycle"}, 32'(wb_cyc), 32'(end_at));
      else            chk({name, ".wb_cycle_window"}, 32'(wb_cyc >= 60 && wb_cyc <= 70), 32'd1);
    end
  endtask

  initial begin
    drive_quiet();
    #2;
    chk("reset.stall",     32'(bus.stall), 32'd0);
    chk("reset.ctrl",      32'({bus.ctrl_MULT, bus.ctrl_DIV}), 32'd0);
    chk("reset.wb",        32'({bus.wb_valid, bus.wb_rd}), 32'd0);
    chk("reset.wb_data",   bus.wb_data, 32'd0);
    chk("reset.operandA",  bus.data_operandA, 32'd0);
    chk("reset.timeout",   32'(bus.err_timeout), 32'd0);
    #10 ctrl_reset_n = 1'b1;

    //     name          m     d     a             b           rd  rdy res           exc   fl end stale  wb    wrd  wdata         to
    run_op("mul7x6",     1'b1, 1'b0, 32'd7,        32'd6,      3,  18, 32'd42,       1'b0, 0, 19, 1'b0, 1'b1, 3,   32'd42,       1'b0);
    run_op("div_by0",    1'b0, 1'b1, 32'd100,      32'd0,      5,  6,  32'd0,        1'b1, 0, 7,  1'b0, 1'b1, 30,  32'd5,        1'b0);
    run_op("mul_ovf",    1'b1, 1'b0, 32'h7FFFFFFF, 32'd2,      4,  4,  32'hFFFFFFFE, 1'b1, 0, 5,  1'b0, 1'b1, 30,  32'd4,        1'b0);
    run_op("stale_rdy",  1'b0, 1'b1, 32'd20,       32'd4,      7,  6,  32'd5,        1'b0, 0, 7,  1'b1, 1'b1, 7,   32'd5,        1'b0);
    run_op("div_flush",  1'b0, 1'b1, 32'd9,        32'd3,      6,  8,  32'd3,        1'b0, 5, 10, 1'b0, 1'b0, 0,   32'd0,        1'b0);
    run_op("iss_flush",  1'b1, 1'b0, 32'd2,        32'd2,      8,  0,  32'd4,        1'b0, 1, 3,  1'b0, 1'b0, 0,   32'd0,        1'b0);
    run_op("timeout",    1'b1, 1'b0, 32'd11,       32'd13,     9,  0,  32'd0,        1'b0, 0, 0,  1'b0, 1'b1, 30,  32'd7,        1'b1);
    run_op("mul_rd0",    1'b1, 1'b0, 32'd9,        32'd11,     0,  3,  32'd99,       1'b0, 0, 4,  1'b0, 1'b0, 0,   32'd0,        1'b0);
    run_op("both_flags", 1'b1, 1'b1, 32'd3,        32'd4,      2,  3,  32'd12,       1'b0, 0, 4,  1'b0, 1'b1, 2,   32'd12,       1'b0);

    // Reset in WAIT clears everything immediately.
    @(posedge clock); #1;
    bus.ex_valid = 1'b1; bus.ex_is_mult = 1'b1; bus.ex_operandA = 32'd5;
    bus.ex_operandB = 32'd5; bus.ex_rd = 5'd1;
    @(posedge clock); #1;
    drive_quiet();
    @(posedge clock); #1;
    @(posedge clock); #2;
    chk("wait.stall_before_reset", 32'(bus.stall), 32'd1);
    ctrl_reset_n = 1'b0;
    #1;
    chk("rst_wait.stall",    32'(bus.stall), 32'd0);
    chk("rst_wait.ctrl",     32'({bus.ctrl_MULT, bus.ctrl_DIV}), 32'd0);
    chk("rst_wait.wb",       32'({bus.wb_valid, bus.wb_rd}), 32'd0);
    chk("rst_wait.operands", bus.data_operandA | bus.data_operandB, 32'd0);
    chk("rst_wait.timeout",  32'(bus.err_timeout), 32'd0);
    #10 ctrl_reset_n = 1'b1;

    run_op("after_rst",  1'b1, 1'b0, 32'd5,        32'd5,      1,  3,  32'd25,       1'b0, 0, 4,  1'b0, 1'b1, 1,   32'd25,       1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
